// File: rtl/toggle_pkg.sv
// Shared definitions for the toggle requester: FSM state encoding and
// default parameter values used by the requester and its counters.
package toggle_pkg;

    localparam int CNT_W_DEF   = 8;
    localparam int GAP_W_DEF   = 8;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/toggle_cycle_counter.sv
// Loadable down-counter with a zero flag. Load has priority over decrement;
// the count parks at zero instead of wrapping.
module toggle_cycle_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_r;

    // Count register: load, decrement towards zero, or hold.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_value;
        end else if (dec && (count_r != {W{1'b0}})) begin
            count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/toggle_requester.sv
// Initiator side of the ready/done toggle handshake. Issues num_req requests,
// spaced by max(gap_cycles,1) low cycles, checks that output1 alternates
// (first response expected 1) and counts accepted responses.
// Optional feature macro: TOGGLE_REQUESTER_TIMEOUT_EN adds a per-request
// timeout of TIMEOUT cycles; without it REQ waits indefinitely and timeout=0.
module toggle_requester
    import toggle_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int GAP_W   = GAP_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_req,
    input  logic [GAP_W-1:0] gap_cycles,
    input  logic             done,
    input  logic             output1,
    output logic             ready,
    output logic             busy,
    output logic             finished,
    output logic [CNT_W-1:0] resp_count,
    output logic             mismatch,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [GAP_W-1:0] GAP_ONE = {{(GAP_W-1){1'b0}}, 1'b1};

    // GAP lasts max(g,1) cycles; the counter runs one step per GAP cycle and
    // the exit happens on the cycle that sees zero, hence the minus one.
    function automatic logic [GAP_W-1:0] gap_reload(input logic [GAP_W-1:0] g);
        if (g == {GAP_W{1'b0}}) begin
            return {GAP_W{1'b0}};
        end else begin
            return g - GAP_ONE;
        end
    endfunction

    state_t           state_r;
    logic             ready_r;
    logic             busy_r;
    logic             finished_r;
    logic [CNT_W-1:0] resp_count_r;
    logic             mismatch_r;
    logic             timeout_r;
    logic             exp_r;
    logic [CNT_W-1:0] num_req_r;
    logic [GAP_W-1:0] gap_r;

    logic [CNT_W-1:0] resp_next_s;
    logic             last_resp_s;
    logic             accept_s;
    logic             gap_load_s;
    logic [GAP_W-1:0] gap_value_s;
    logic             gap_dec_s;
    logic             gap_zero_s;
    logic             to_expired_s;

    // Response bookkeeping and gap counter control.
    always_comb begin
        resp_next_s = resp_count_r + CNT_ONE;
        last_resp_s = (resp_next_s == num_req_r);
        accept_s    = (state_r == ST_REQ) && done;
        gap_load_s  = accept_s;
        gap_value_s = gap_reload(gap_r);
        gap_dec_s   = (state_r == ST_GAP);
    end

    toggle_cycle_counter #(
        .W(GAP_W)
    ) u_gap_counter (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (gap_load_s),
        .load_value (gap_value_s),
        .dec        (gap_dec_s),
        .zero       (gap_zero_s)
    );

`ifdef TOGGLE_REQUESTER_TIMEOUT_EN
    localparam int             TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT - 1);

    logic to_load_s;
    logic to_dec_s;
    logic to_zero_s;

    // Reload the timeout budget on every entry into REQ; count while in REQ.
    always_comb begin
        to_load_s = ((state_r == ST_IDLE) && start && (num_req != {CNT_W{1'b0}}))
                  || ((state_r == ST_GAP) && gap_zero_s);
        to_dec_s  = (state_r == ST_REQ);
    end

    toggle_cycle_counter #(
        .W(TO_W)
    ) u_timeout_counter (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (to_load_s),
        .load_value (TO_LOAD),
        .dec        (to_dec_s),
        .zero       (to_zero_s)
    );

    assign to_expired_s = to_zero_s;
`else
    assign to_expired_s = 1'b0;
`endif

    // Main handshake FSM with registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            ready_r      <= 1'b0;
            busy_r       <= 1'b0;
            finished_r   <= 1'b0;
            resp_count_r <= {CNT_W{1'b0}};
            mismatch_r   <= 1'b0;
            timeout_r    <= 1'b0;
            exp_r        <= 1'b0;
            num_req_r    <= {CNT_W{1'b0}};
            gap_r        <= {GAP_W{1'b0}};
        end else begin
            finished_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        num_req_r    <= num_req;
                        gap_r        <= gap_cycles;
                        resp_count_r <= {CNT_W{1'b0}};
                        mismatch_r   <= 1'b0;
                        timeout_r    <= 1'b0;
                        exp_r        <= 1'b0;
                        busy_r       <= 1'b1;
                        if (num_req != {CNT_W{1'b0}}) begin
                            state_r <= ST_REQ;
                            ready_r <= 1'b1;
                        end else begin
                            state_r    <= ST_FIN;
                            finished_r <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (done) begin
                        ready_r      <= 1'b0;
                        resp_count_r <= resp_next_s;
                        exp_r        <= ~exp_r;
                        if (output1 != ~exp_r) begin
                            mismatch_r <= 1'b1;
                        end
                        if (last_resp_s) begin
                            state_r    <= ST_FIN;
                            finished_r <= 1'b1;
                        end else begin
                            state_r <= ST_GAP;
                        end
                    end else if (to_expired_s) begin
                        timeout_r  <= 1'b1;
                        ready_r    <= 1'b0;
                        state_r    <= ST_FIN;
                        finished_r <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_zero_s) begin
                        state_r <= ST_REQ;
                        ready_r <= 1'b1;
                    end
                end
                ST_FIN: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ready      = ready_r;
    assign busy       = busy_r;
    assign finished   = finished_r;
    assign resp_count = resp_count_r;
    assign mismatch   = mismatch_r;
`ifdef TOGGLE_REQUESTER_TIMEOUT_EN
    assign timeout    = timeout_r;
`else
    assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_toggle_requester.sv
// Directed, table-driven bench for toggle_requester (TIMEOUT overridden to 8).
module tb_toggle_requester;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] num_req;
    logic [7:0] gap_cycles;
    logic       done;
    logic       output1;
    logic       ready;
    logic       busy;
    logic       finished;
    logic [7:0] resp_count;
    logic       mismatch;
    logic       timeout;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clock = ~clock;

    toggle_requester #(
        .CNT_W   (8),
        .GAP_W   (8),
        .TIMEOUT (8)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .num_req    (num_req),
        .gap_cycles (gap_cycles),
        .done       (done),
        .output1    (output1),
        .ready      (ready),
        .busy       (busy),
        .finished   (finished),
        .resp_count (resp_count),
        .mismatch   (mismatch),
        .timeout    (timeout)
    );

    typedef struct {
        logic       start;
        logic [7:0] num;
        logic [7:0] gap;
        logic       done;
        logic       out1;
        logic       e_ready;
        logic       e_busy;
        logic       e_fin;
        logic [7:0] e_rc;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        start      = 1'b0;
        num_req    = 8'd0;
        gap_cycles = 8'd0;
        done       = 1'b0;
        output1    = 1'b0;
    endtask

    // Full num_req=3 / gap=2 run; bad2 makes the second response return 1.
    task automatic run_table(input bit bad2);
        for (int i = 0; i < 15; i++) begin
            start      = tbl[i].start;
            num_req    = tbl[i].num;
            gap_cycles = tbl[i].gap;
            done       = tbl[i].done;
            output1    = (bad2 && i == 8) ? 1'b1 : tbl[i].out1;
            tick();
            chk($sformatf("row%0d.ready", i), 32'(ready), 32'(tbl[i].e_ready));
            chk($sformatf("row%0d.busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("row%0d.finished", i), 32'(finished), 32'(tbl[i].e_fin));
            chk($sformatf("row%0d.resp_count", i), 32'(resp_count), 32'(tbl[i].e_rc));
            chk($sformatf("row%0d.mismatch", i), 32'(mismatch), (bad2 && i >= 8) ? 32'd1 : 32'd0);
        end
        idle_inputs();
    endtask

    initial begin
        logic [6:0] g0_ready;
        logic [6:0] g0_fin;
        logic [7:0] g0_rc [7];

        tbl[0]  = '{1'b1, 8'd3, 8'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
        tbl[1]  = '{1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
        tbl[2]  = '{1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
        tbl[3]  = '{1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1};
        tbl[4]  = '{1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
        tbl[5]  = '{1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1};
        tbl[6]  = '{1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1};
        tbl[7]  = '{1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1};
        tbl[8]  = '{1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2};
        tbl[9]  = '{1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2};
        tbl[10] = '{1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2};
        tbl[11] = '{1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2};
        tbl[12] = '{1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2};
        tbl[13] = '{1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd3};
        tbl[14] = '{1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3};

        // gap=0 with done stuck high: expected values after each edge.
        g0_ready = 7'b0010101;   // bit k = ready after edge k (edge 0 = start)
        g0_fin   = 7'b0100000;
        g0_rc    = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3};

        // Reset state
        reset_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        chk("reset.ready", 32'(ready), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.finished", 32'(finished), 32'd0);
        chk("reset.resp_count", 32'(resp_count), 32'd0);
        chk("reset.mismatch", 32'(mismatch), 32'd0);
        chk("reset.timeout", 32'(timeout), 32'd0);
        reset_n = 1'b1;
        tick();

        // Clean run, then the same run with a wrong second response
        run_table(1'b0);
        tick();
        run_table(1'b1);
        tick();

        // num_req = 0: one-cycle busy and finished, no request
        start   = 1'b1;
        num_req = 8'd0;
        tick();
        idle_inputs();
        chk("zero.finished", 32'(finished), 32'd1);
        chk("zero.busy", 32'(busy), 32'd1);
        chk("zero.ready", 32'(ready), 32'd0);
        chk("zero.mismatch_cleared", 32'(mismatch), 32'd0);
        tick();
        chk("zero.finished_end", 32'(finished), 32'd0);
        chk("zero.busy_end", 32'(busy), 32'd0);
        chk("zero.ready_end", 32'(ready), 32'd0);
        tick();
        chk("zero.ready_idle", 32'(ready), 32'd0);

        // gap = 0, done held high: ready alternates, one response per REQ
        start      = 1'b1;
        num_req    = 8'd3;
        gap_cycles = 8'd0;
        done       = 1'b1;
        output1    = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            start = 1'b0;
            chk($sformatf("gap0.e%0d.ready", k), 32'(ready), 32'(g0_ready[k]));
            chk($sformatf("gap0.e%0d.finished", k), 32'(finished), 32'(g0_fin[k]));
            chk($sformatf("gap0.e%0d.resp_count", k), 32'(resp_count), 32'(g0_rc[k]));
        end
        idle_inputs();
        tick();
        chk("gap0.busy_end", 32'(busy), 32'd0);

        // No done at all
        start      = 1'b1;
        num_req    = 8'd2;
        gap_cycles = 8'd1;
        tick();
        idle_inputs();
`ifdef TOGGLE_REQUESTER_TIMEOUT_EN
        for (int k = 1; k < 8; k++) begin
            tick();
            chk($sformatf("to.e%0d.ready", k), 32'(ready), 32'd1);
            chk($sformatf("to.e%0d.timeout", k), 32'(timeout), 32'd0);
        end
        tick();
        chk("to.ready_drop", 32'(ready), 32'd0);
        chk("to.timeout", 32'(timeout), 32'd1);
        chk("to.finished", 32'(finished), 32'd1);
        tick();
        chk("to.finished_end", 32'(finished), 32'd0);
        chk("to.busy_end", 32'(busy), 32'd0);
`else
        for (int k = 1; k < 100; k++) begin
            tick();
        end
        chk("noto.ready_held", 32'(ready), 32'd1);
        chk("noto.busy_held", 32'(busy), 32'd1);
        chk("noto.timeout", 32'(timeout), 32'd0);
        chk("noto.finished", 32'(finished), 32'd0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
`endif

        // Asynchronous reset in the middle of a GAP
        start      = 1'b1;
        num_req    = 8'd3;
        gap_cycles = 8'd4;
        tick();
        idle_inputs();
        done    = 1'b1;
        output1 = 1'b1;
        tick();
        idle_inputs();
        chk("rst.pre_rc", 32'(resp_count), 32'd1);
        tick();
        chk("rst.pre_busy", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst.async_ready", 32'(ready), 32'd0);
        chk("rst.async_busy", 32'(busy), 32'd0);
        chk("rst.async_resp_count", 32'(resp_count), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        run_table(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
